// File: rtl/baser_pcs_loopback.sv
// Simplified 10GBASE-R PCS: 64b/66b encode + scramble on TX,
// descramble + decode on RX, with an internal TX->RX loopback mux.
module baser_pcs_loopback #(
    parameter int XGMII_WIDTH_BASER = 64
) (
    input  logic                           clk_156,
    input  logic                           rst_156,
    input  logic [XGMII_WIDTH_BASER-1:0]   baserTx_d,
    input  logic [XGMII_WIDTH_BASER/8-1:0] baserTx_c,
    output logic [XGMII_WIDTH_BASER-1:0]   baserRx_d,
    output logic [XGMII_WIDTH_BASER/8-1:0] baserRx_c,
    output logic [65:0]                    tx_block,
    input  logic [65:0]                    rx_block,
    input  logic                           loopback_en
);

    localparam logic [63:0] IDLE_D = {8{8'h07}};
    localparam logic [63:0] ERR_D  = {8{8'hFE}};

    function automatic logic [7:0] term_type(input int k);
        case (k)
            0:       return 8'h87;
            1:       return 8'h99;
            2:       return 8'hAA;
            3:       return 8'hB4;
            4:       return 8'hCC;
            5:       return 8'hD2;
            6:       return 8'hE1;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [65:0] encode(input logic [63:0] d,
                                           input logic [7:0]  c);
        logic [65:0] blk;
        logic [63:0] pay;
        logic        ok;
        blk = {{8{7'h1E}}, 8'h1E, 2'b10};
        if (c == 8'h00) begin
            blk = {d, 2'b01};
        end else if (c == 8'hFF && d == IDLE_D) begin
            blk = {56'h0, 8'h1E, 2'b10};
        end else if (c == 8'h01 && d[7:0] == 8'hFB) begin
            blk = {d[63:8], 8'h78, 2'b10};
        end else begin
            for (int k = 0; k < 8; k++) begin
                ok = (c == (8'hFF << k)) && (d[8*k +: 8] == 8'hFD);
                for (int j = 0; j < 8; j++)
                    if (j > k && d[8*j +: 8] != 8'h07) ok = 1'b0;
                if (ok) begin
                    pay = '0;
                    for (int j = 0; j < 7; j++)
                        if (j < k) pay[8*j+8 +: 8] = d[8*j +: 8];
                    pay[7:0] = term_type(k);
                    blk = {pay, 2'b10};
                end
            end
        end
        return blk;
    endfunction

    // Bit-serial x^58+x^39+1; desc selects whether the line bit or the result feeds the history.
    function automatic logic [121:0] lfsr58(input logic [63:0] din,
                                            input logic [57:0] st,
                                            input logic        desc);
        logic [57:0] s;
        logic [63:0] dout;
        s    = st;
        dout = '0;
        for (int i = 0; i < 64; i++) begin
            dout[i] = din[i] ^ s[38] ^ s[57];
            s = {s[56:0], desc ? din[i] : dout[i]};
        end
        return {s, dout};
    endfunction

    function automatic logic [71:0] decode(input logic [65:0] blk);
        logic [63:0] p;
        logic [63:0] sh;
        logic [63:0] d;
        logic [7:0]  c;
        int          k;
        p  = blk[65:2];
        sh = p >> 8;
        d  = ERR_D;
        c  = 8'hFF;
        k  = -1;
        case (blk[1:0])
            2'b01: begin
                d = p;
                c = 8'h00;
            end
            2'b10: begin
                case (p[7:0])
                    8'h1E: if (p[63:8] == 56'h0) d = IDLE_D;
                    8'h78: begin
                        d = {p[63:8], 8'hFB};
                        c = 8'h01;
                    end
                    8'h87: k = 0;
                    8'h99: k = 1;
                    8'hAA: k = 2;
                    8'hB4: k = 3;
                    8'hCC: k = 4;
                    8'hD2: k = 5;
                    8'hE1: k = 6;
                    8'hFF: k = 7;
                    default: ;
                endcase
            end
            default: ;
        endcase
        if (k >= 0) begin
            for (int j = 0; j < 8; j++) begin
                if (j < k)       d[8*j +: 8] = sh[8*j +: 8];
                else if (j == k) d[8*j +: 8] = 8'hFD;
                else             d[8*j +: 8] = 8'h07;
            end
            c = 8'hFF << k;
        end
        return {c, d};
    endfunction

    logic [65:0] enc_blk;
    logic [57:0] scr_state;
    logic [57:0] dsc_state;
    logic [65:0] dsc_blk;
    logic [65:0] rx_src;
    logic [57:0] scr_next;
    logic [57:0] dsc_next;
    logic [63:0] scr_pay;
    logic [63:0] dsc_pay;

    assign rx_src = loopback_en ? tx_block : rx_block;
    assign {scr_next, scr_pay} = lfsr58(enc_blk[65:2], scr_state, 1'b0);
    assign {dsc_next, dsc_pay} = lfsr58(rx_src[65:2], dsc_state, 1'b1);

    always_ff @(posedge clk_156 or posedge rst_156) begin
        if (rst_156) begin
            enc_blk   <= '0;
            scr_state <= '1;
            tx_block  <= '0;
            dsc_state <= '1;
            dsc_blk   <= '0;
            baserRx_d <= IDLE_D;
            baserRx_c <= 8'hFF;
        end else begin
            enc_blk   <= encode(baserTx_d, baserTx_c);
            scr_state <= scr_next;
            tx_block  <= {scr_pay, enc_blk[1:0]};
            dsc_state <= dsc_next;
            dsc_blk   <= {dsc_pay, rx_src[1:0]};
            {baserRx_c, baserRx_d} <= decode(dsc_blk);
        end
    end

endmodule

// File: tb/tb_baser_pcs_loopback.sv
// Bench for baser_pcs_loopback: directed vector table, randomized
// loopback traffic against a reference model, and reset/loopback corners.
module tb_baser_pcs_loopback;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        logic [1:0]  hdr;
        logic [7:0]  ty;
        logic [63:0] rd;
        logic [7:0]  rc;
    } vec_t;

    localparam logic [63:0] IDLE = {8{8'h07}};
    localparam logic [63:0] ERRW = {8{8'hFE}};
    localparam logic [7:0] TTYPE [8] =
        '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

    logic        clk_156 = 1'b0;
    logic        rst_156;
    logic [63:0] baserTx_d;
    logic [7:0]  baserTx_c;
    logic [63:0] baserRx_d;
    logic [7:0]  baserRx_c;
    logic [65:0] tx_block;
    logic [65:0] rx_block;
    logic        loopback_en;

    int   total  = 0;
    int   passed = 0;
    int   m      = 0;
    vec_t hist[$];
    bit   sh[$];
    bit   dh[$];
    vec_t tbl[13];

    baser_pcs_loopback #(.XGMII_WIDTH_BASER(64)) dut (
        .clk_156    (clk_156),
        .rst_156    (rst_156),
        .baserTx_d  (baserTx_d),
        .baserTx_c  (baserTx_c),
        .baserRx_d  (baserRx_d),
        .baserRx_c  (baserRx_c),
        .tx_block   (tx_block),
        .rx_block   (rx_block),
        .loopback_en(loopback_en)
    );

    always #5 clk_156 = ~clk_156;

    task automatic chk(input string nm, input logic [71:0] act,
                       input logic [71:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, m);
    endtask

    // Reference encoder, written from the block-type rules.
    function automatic logic [65:0] m_encode(input logic [63:0] d,
                                             input logic [7:0]  c);
        int          t;
        logic        ok;
        logic [64:0] mask;
        if (c == 8'h00) return {d, 2'b01};
        if (c == 8'hFF && d == IDLE) return {56'h0, 8'h1E, 2'b10};
        if (c == 8'h01 && d[7:0] == 8'hFB) return {d[63:8], 8'h78, 2'b10};
        t = 0;
        while (!c[t]) t++;
        ok = (c == 8'(8'hFF << t)) && (d[8*t +: 8] == 8'hFD);
        for (int j = t + 1; j < 8; j++) ok &= (d[8*j +: 8] == 8'h07);
        if (ok) begin
            mask = (65'h1 << (8*t + 8)) - 65'h1;
            return {({d[55:0], 8'h00} & mask[63:0]) | {56'h0, TTYPE[t]}, 2'b10};
        end
        return {{8{7'h1E}}, 8'h1E, 2'b10};
    endfunction

    task automatic scr_blk(input logic [63:0] p, output logic [63:0] o);
        for (int i = 0; i < 64; i++) begin
            o[i] = p[i] ^ sh[19] ^ sh[0];
            sh.push_back(o[i]);
            void'(sh.pop_front());
        end
    endtask

    task automatic dsc_blk(input logic [63:0] p, output logic [63:0] o);
        for (int i = 0; i < 64; i++) begin
            o[i] = p[i] ^ dh[19] ^ dh[0];
            dh.push_back(p[i]);
            void'(dh.pop_front());
        end
    endtask

    function automatic vec_t mk(input logic [63:0] d, input logic [7:0] c);
        vec_t        v;
        logic [65:0] b;
        logic        bad;
        b     = m_encode(d, c);
        bad   = (b[9:2] == 8'h1E) && (b[65:10] != 56'h0);
        v.d   = d;
        v.c   = c;
        v.hdr = b[1:0];
        v.ty  = b[9:2];
        v.rd  = bad ? ERRW : d;
        v.rc  = bad ? 8'hFF : c;
        return v;
    endfunction

    // One loopback cycle: drive v, clock, then check TX and RX pipelines.
    task automatic run(input vec_t v);
        logic [65:0] blk;
        logic [63:0] so;
        logic [63:0] dp;
        baserTx_d = v.d;
        baserTx_c = v.c;
        hist.push_back(v);
        @(posedge clk_156);
        #1;
        m++;
        blk = (m == 1) ? 66'h0 : m_encode(hist[m-2].d, hist[m-2].c);
        scr_blk(blk[65:2], so);
        chk("tx_block", {6'h0, tx_block}, {6'h0, so, blk[1:0]});
        dsc_blk(tx_block[65:2], dp);
        if (m >= 2) begin
            chk("tx_hdr", {70'h0, tx_block[1:0]}, {70'h0, hist[m-2].hdr});
            chk("tx_type", {64'h0, dp[7:0]}, {64'h0, hist[m-2].ty});
        end
        if (m >= 4)
            chk("rx_word", {baserRx_c, baserRx_d}, {hist[m-4].rc, hist[m-4].rd});
    endtask

    task automatic do_reset();
        rst_156 = 1'b1;
        #2;
        chk("rst_tx", {6'h0, tx_block}, 72'h0);
        chk("rst_rx", {baserRx_c, baserRx_d}, {8'hFF, IDLE});
        @(posedge clk_156);
        @(posedge clk_156);
        #1;
        rst_156 = 1'b0;
        m = 0;
        hist.delete();
        sh.delete();
        dh.delete();
        for (int i = 0; i < 58; i++) begin
            sh.push_back(1'b1);
            dh.push_back(1'b1);
        end
    endtask

    task automatic gen_rand(output vec_t v);
        logic [63:0] d;
        logic [7:0]  c;
        int          t;
        d = {$urandom, $urandom};
        c = 8'($urandom);
        t = $urandom_range(0, 7);
        case ($urandom_range(0, 5))
            0: c = 8'h00;
            1: begin d = IDLE; c = 8'hFF; end
            2: begin d[7:0] = 8'hFB; c = 8'h01; end
            3, 4: begin
                for (int j = t + 1; j < 8; j++) d[8*j +: 8] = 8'h07;
                d[8*t +: 8] = 8'hFD;
                c = 8'hFF << t;
                if ($urandom_range(0, 1) == 1) c[$urandom_range(0, 7)] ^= 1'b1;
            end
            default: ;
        endcase
        v = mk(d, c);
    endtask

    initial begin
        vec_t v;
        tbl[0]  = '{IDLE, 8'hFF, 2'b10, 8'h1E, IDLE, 8'hFF};
        tbl[1]  = '{64'hD6D5D4D3D2D1D0FB, 8'h01, 2'b10, 8'h78, 64'hD6D5D4D3D2D1D0FB, 8'h01};
        tbl[2]  = '{64'h0011223344556677, 8'h00, 2'b01, 8'h77, 64'h0011223344556677, 8'h00};
        tbl[3]  = '{64'h07070707070707FD, 8'hFF, 2'b10, 8'h87, 64'h07070707070707FD, 8'hFF};
        tbl[4]  = '{64'h070707070707FD11, 8'hFE, 2'b10, 8'h99, 64'h070707070707FD11, 8'hFE};
        tbl[5]  = '{64'h0707070707FD2211, 8'hFC, 2'b10, 8'hAA, 64'h0707070707FD2211, 8'hFC};
        tbl[6]  = '{64'h07070707FD332211, 8'hF8, 2'b10, 8'hB4, 64'h07070707FD332211, 8'hF8};
        tbl[7]  = '{64'h070707FD44332211, 8'hF0, 2'b10, 8'hCC, 64'h070707FD44332211, 8'hF0};
        tbl[8]  = '{64'h0707FD5544332211, 8'hE0, 2'b10, 8'hD2, 64'h0707FD5544332211, 8'hE0};
        tbl[9]  = '{64'h07FD665544332211, 8'hC0, 2'b10, 8'hE1, 64'h07FD665544332211, 8'hC0};
        tbl[10] = '{64'hFD77665544332211, 8'h80, 2'b10, 8'hFF, 64'hFD77665544332211, 8'h80};
        tbl[11] = '{64'h0707070755070707, 8'h10, 2'b10, 8'h1E, ERRW, 8'hFF};
        tbl[12] = '{IDLE, 8'hFF, 2'b10, 8'h1E, IDLE, 8'hFF};

        baserTx_d   = IDLE;
        baserTx_c   = 8'hFF;
        rx_block    = '0;
        loopback_en = 1'b1;
        rst_156     = 1'b0;
        #3;
        do_reset();

        for (int i = 0; i < 8; i++) run(tbl[0]);
        for (int i = 0; i < 13; i++) run(tbl[i]);
        for (int i = 0; i < 4; i++) run(tbl[0]);

        for (int i = 0; i < 300; i++) begin
            gen_rand(v);
            run(v);
        end
        for (int i = 0; i < 4; i++) run(tbl[0]);

        run(tbl[1]);
        run(tbl[2]);
        do_reset();
        for (int i = 0; i < 10; i++) run(tbl[0]);

        loopback_en = 1'b0;
        rx_block = {$urandom, $urandom, 2'b11};
        @(posedge clk_156);
        @(posedge clk_156);
        #1;
        chk("ext_hdr11", {baserRx_c, baserRx_d}, {8'hFF, ERRW});
        rx_block = {$urandom, $urandom, 2'b00};
        @(posedge clk_156);
        @(posedge clk_156);
        #1;
        chk("ext_hdr00", {baserRx_c, baserRx_d}, {8'hFF, ERRW});
        rx_block = {$urandom, $urandom, 2'b01};
        @(posedge clk_156);
        @(posedge clk_156);
        #1;
        chk("ext_data_c", {64'h0, baserRx_c}, 72'h0);

        loopback_en = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) run(tbl[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
